// File: rtl/ssd_pkg.sv
// Shared constants and hex-to-segment mapping for the seven-segment scan driver.
// Segment codes are active-low {a,b,c,d,e,f,g}.
package ssd_pkg;

  localparam int DEF_SCAN_DIV_BITS  = 18;
  localparam int DEF_DEAD_CYCLES    = 16;
  localparam int DEF_BLINK_DIV_BITS = 25;

  localparam logic [6:0] SEG_0   = 7'b0000001;
  localparam logic [6:0] SEG_1   = 7'b1001111;
  localparam logic [6:0] SEG_2   = 7'b0010010;
  localparam logic [6:0] SEG_3   = 7'b0000110;
  localparam logic [6:0] SEG_4   = 7'b1001100;
  localparam logic [6:0] SEG_5   = 7'b0100100;
  localparam logic [6:0] SEG_6   = 7'b0100000;
  localparam logic [6:0] SEG_7   = 7'b0001111;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0000100;
  localparam logic [6:0] SEG_A   = 7'b0001000;
  localparam logic [6:0] SEG_B   = 7'b1100000;
  localparam logic [6:0] SEG_C   = 7'b0110001;
  localparam logic [6:0] SEG_D   = 7'b1000010;
  localparam logic [6:0] SEG_E   = 7'b0110000;
  localparam logic [6:0] SEG_F   = 7'b0111000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational hex digit to active-low seven-segment pattern.
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(hex);

endmodule

// File: rtl/ssd_scan_driver.sv
// N-digit multiplexed seven-segment driver: prescaled scan, frame snapshot, LZ suppression, dead time.
// Optional digit blinking is compiled in with the SSD_BLINK_EN macro.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV_BITS  = DEF_SCAN_DIV_BITS,
  parameter int DEAD_CYCLES    = DEF_DEAD_CYCLES,
  parameter int BLINK_DIV_BITS = DEF_BLINK_DIV_BITS,
  parameter int IDX_W          = $clog2(NUM_DIGITS)
) (
  input  logic                    board_clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_suppress,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp_out,
  output logic                    frame_tick
);

  localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SCAN_DIV_BITS-1:0] DEAD_LIM = SCAN_DIV_BITS'(DEAD_CYCLES);

  logic [SCAN_DIV_BITS-1:0] prescaler;
  logic [IDX_W-1:0]         index;
  logic                     tick;
  logic                     last_digit;

  logic [4*NUM_DIGITS-1:0]  snap_digits;
  logic [NUM_DIGITS-1:0]    snap_blank;
  logic [NUM_DIGITS-1:0]    snap_dp;
  logic                     snap_lz;

  logic [NUM_DIGITS-1:0]    lz_dark;
  logic                     zero_run;
  logic [3:0]               cur_hex;
  logic [6:0]               dec_seg;
  logic                     blink_off;
  logic                     digit_dark;

  assign tick       = enable && (&prescaler);
  assign last_digit = (index == LAST_IDX);

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      index     <= '0;
    end else if (enable) begin
      prescaler <= prescaler + 1'b1;
      if (tick) index <= last_digit ? '0 : index + 1'b1;
    end
  end

  // Snapshot reloads only at frame wrap so a frame never mixes old and new values.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      snap_digits <= '0;
      snap_blank  <= '1;
      snap_dp     <= '0;
      snap_lz     <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      frame_tick <= tick && last_digit;
      if (tick && last_digit) begin
        snap_digits <= digits;
        snap_blank  <= blank;
        snap_dp     <= dp;
        snap_lz     <= lz_suppress;
      end
    end
  end

  // Walk down from the top digit; digit 0 is never suppressed.
  always_comb begin
    lz_dark  = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run & (snap_digits[4*i +: 4] == 4'h0);
      lz_dark[i] = snap_lz & zero_run;
    end
  end

  assign cur_hex = snap_digits[4*int'(index) +: 4];

  ssd_hex_decoder u_dec (
    .hex (cur_hex),
    .seg (dec_seg)
  );

`ifdef SSD_BLINK_EN
  logic [BLINK_DIV_BITS-1:0] blink_cnt;

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset)       blink_cnt <= '0;
    else if (enable) blink_cnt <= blink_cnt + 1'b1;
  end

  // blink_mask is sampled live so blinking can be toggled without waiting a frame.
  assign blink_off = blink_cnt[BLINK_DIV_BITS-1] & blink_mask[index];
`else
  logic unused_blink;
  assign unused_blink = (^blink_mask) ^ (BLINK_DIV_BITS > 0);
  assign blink_off    = 1'b0;
`endif

  assign digit_dark = snap_blank[index] | lz_dark[index] | blink_off;

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      an     <= '1;
      seg    <= SEG_OFF;
      dp_out <= 1'b1;
    end else if (!enable) begin
      an     <= '1;
      seg    <= SEG_OFF;
      dp_out <= 1'b1;
    end else begin
      an     <= (prescaler < DEAD_LIM) ? '1 : ~(NUM_DIGITS'(1) << index);
      seg    <= digit_dark ? SEG_OFF : dec_seg;
      dp_out <= ~(snap_dp[index] & ~blink_off);
    end
  end

endmodule

// File: doc/ssd_scan_driver.md
Name: ssd_scan_driver

Overview:
Parametrised N-digit multiplexed seven-segment display driver. It replaces the per-design hand-coded anode scan and hex-to-segment logic in the board top level.
- Runs its own scan prescaler from board_clk.
- Captures a frame-coherent snapshot of the digit values.
- Adds leading-zero suppression, per-digit decimal points and an anti-ghosting anode dead time.
- Optionally blinks selected digits.
- Sits between the game/score logic and the An*/Ca..Cg/Dp board pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8).
SCAN_DIV_BITS, 18, prescaler width; each digit is active for 2^SCAN_DIV_BITS clocks.
DEAD_CYCLES, 16, clocks at the start of each digit slot with all anodes off; must be < 2^SCAN_DIV_BITS.
BLINK_DIV_BITS, 25, blink counter width; blink phase = counter MSB.
IDX_W, $clog2(NUM_DIGITS), digit index width (derived; do not override).

Ports:
board_clk  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-high
enable  in  1  1 = scanning; 0 = counters frozen, display dark
digits  in  4*NUM_DIGITS  hex value per digit; digit i = digits[4i+3:4i]; digit 0 is rightmost
blank  in  NUM_DIGITS  1 = force digit dark
dp  in  NUM_DIGITS  1 = light that digit's decimal point
blink_mask  in  NUM_DIGITS  1 = digit blinks (only with SSD_BLINK_EN)
lz_suppress  in  1  1 = blank leading zeros
an  out  NUM_DIGITS  anodes, active-low
seg  out  7  cathodes {a,b,c,d,e,f,g}, active-low
dp_out  out  1  decimal-point cathode, active-low
frame_tick  out  1  one-cycle pulse when the snapshot reloads

Behaviour:
- Reset state:
  - prescaler = 0, index = 0, blink counter = 0.
  - Snapshot: digits = 0, blank = all 1s, dp = 0.
  - an = all 1s, seg = 7'b1111111, dp_out = 1, frame_tick = 0.
- Scan timing:
  - tick = enable && prescaler == all-ones. The prescaler wraps to 0 on tick.
  - On tick: index <= (index == NUM_DIGITS-1) ? 0 : index+1.
- Snapshot:
  - On a tick where index == NUM_DIGITS-1, the snapshot registers load digits, blank, dp and lz_suppress.
  - frame_tick is asserted the following cycle.
  - Inputs changing mid-frame never appear until the next wrap.
  - After reset, the first frame is dark.
- Digit decode: hex to active-low segments {a..g}.
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111.
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- Leading-zero suppression (snapshot lz_suppress = 1):
  - Digit i is dark if it and every digit above it are 0.
  - Digit 0 is never suppressed. Its dp still lights if set.
- A dark digit drives seg = 1111111. Its anode is still driven.
- Outputs are registered and reflect the current prescaler/index/snapshot state with 1-cycle latency.
- Dead time: while prescaler < DEAD_CYCLES, an = all 1s (seg/dp_out may already show the new digit).
  - Otherwise an[index] = 0 and all other anodes = 1.
- enable = 0:
  - prescaler, index and blink counter hold their values.
  - Next cycle: an = all 1s, seg = 1111111, dp_out = 1.
  - When enable returns, scanning resumes from the held state.
- Reset mid-frame: all state returns to reset values immediately (asynchronous).

Optional Feature:
SSD_BLINK_EN:
- Defined: a free-running blink counter of BLINK_DIV_BITS bits advances while enable = 1. While its MSB = 1, digits whose live blink_mask bit is 1 show seg = 1111111 and dp_out = 1. blink_mask is not snapshotted.
- Undefined: no blink counter, blink_mask is ignored, and the port remains for pin compatibility.

Decomposition:
- Package ssd_pkg:
  - SEG_* segment constants for 0-F and SEG_OFF = 7'b1111111.
  - Function hex_to_seg.
  - Default scan/blink width localparams.
- One combinational sub-module: ssd_hex_decoder (4-bit in, 7-bit active-low out), instantiated once on the muxed digit.

Test Plan:
1. NUM_DIGITS=4, SCAN_DIV_BITS=3, DEAD_CYCLES=2, digits=16'h1234, blank=0, lz=0:
   - First frame after reset is dark.
   - Second frame: an sequence 1110→1101→1011→0111, each low for 6 of 8 cycles; seg 1001100/0000110/0010010/1001111 for digits 0..3.
2. digits changed 16'h1234→16'hABCD mid-frame:
   - The current frame still shows 1234.
   - ABCD appears after the next frame_tick.
   - frame_tick pulses once every 32 cycles.
3. digits=16'h0050, lz_suppress=1:
   - Digits 3 and 2 show seg=1111111.
   - Digit 1 shows 0100100 (5); digit 0 shows 0000001.
   - With digits=16'h0000, only digit 0 is lit.
4. dp=4'b0100, blank=4'b0001:
   - dp_out=0 only in digit 2's slot.
   - Digit 0 shows seg=1111111 with an[0] still pulsed.
5. enable deasserted mid-slot for 20 cycles, then reasserted:
   - Next cycle: an=1111, seg=1111111.
   - On resume, the same index continues with the prescaler unchanged.
   - Async reset mid-slot: outputs go to reset values with no clock edge.
6. With SSD_BLINK_EN, BLINK_DIV_BITS=6, blink_mask=4'b1000:
   - Digit 3 is dark for 32 cycles, then lit for 32 cycles.
   - Without the macro, digit 3 is always lit.
